// File: rtl/multitap_delay.sv
// rtl/multitap_delay.sv - multi-tap circular-buffer audio delay with delay/mix/echo modes
module multitap_delay #(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 8,
   parameter int NUM_TAPS = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_sample,
   input  logic [NUM_TAPS*ADDR_W-1:0]   offsets,
   input  logic [1:0]                   mode,
   output logic                         out_valid,
   output logic [DATA_W-1:0]            out_sample,
   output logic [NUM_TAPS*DATA_W-1:0]   taps_out,
   output logic [NUM_TAPS-1:0]          tap_primed
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int LOG2  = $clog2(NUM_TAPS);
   localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam int ACC_W = DATA_W + LOG2;

   localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [ADDR_W-1:0] FILL_MAX = '1;
   localparam logic [TAP_W-1:0]  LAST     = TAP_W'(NUM_TAPS - 1);

   typedef enum logic [1:0] {IDLE, READ, MIX} state_t;

   state_t                             state;
   logic [TAP_W-1:0]                   k;
   logic [ADDR_W-1:0]                  wr_ptr;
   logic [ADDR_W-1:0]                  fill;
   logic [DATA_W-1:0]                  in_cap;
   logic [1:0]                         mode_cap;
   logic [NUM_TAPS-1:0][ADDR_W-1:0]    off_cap;
   logic [NUM_TAPS-1:0][DATA_W-1:0]    tap_reg;
   logic [NUM_TAPS-1:0]                prim_reg;

   logic [DATA_W-1:0]                  mem [DEPTH];
   logic [DATA_W-1:0]                  rd_data;
   logic [ADDR_W-1:0]                  rd_addr;

   logic [TAP_W-1:0]                   pend;
   logic [ADDR_W-1:0]                  pend_off;
   logic                               pend_primed;
   logic [DATA_W-1:0]                  pend_val;
   logic [NUM_TAPS-1:0][DATA_W-1:0]    taps_all;
   logic [NUM_TAPS-1:0]                prim_all;
   logic [ACC_W-1:0]                   acc;
   logic [DATA_W-1:0]                  mix_val;
   logic signed [DATA_W+1:0]           e_val;
   logic signed [DATA_W+1:0]           s_val;
   logic [DATA_W-1:0]                  echo_val;
   logic [DATA_W-1:0]                  result;
   logic [DATA_W-1:0]                  wr_val;

   assign in_ready = (state == IDLE);

   // Tap resolution: the RAM word for tap k arrives one cycle after its READ cycle,
   // so each cycle resolves the previously addressed tap (the last one during MIX).
   always_comb begin
      rd_addr     = wr_ptr - off_cap[k];
      pend        = (state == MIX) ? LAST : k - TAP_W'(1);
      pend_off    = off_cap[pend];
      pend_primed = (pend_off <= fill);
      if (pend_off == '0)
         pend_val = in_cap;
      else if (pend_primed)
         pend_val = rd_data;
      else
         pend_val = MID;
      taps_all       = tap_reg;
      taps_all[LAST] = pend_val;
      prim_all       = prim_reg;
      prim_all[LAST] = pend_primed;
   end

   // Result computation for the three modes, valid during MIX.
   always_comb begin
      acc = '0;
      for (int j = 0; j < NUM_TAPS; j++)
         acc = acc + ACC_W'(taps_all[j]);
      mix_val = DATA_W'(acc >> LOG2);

      e_val = $signed({2'b00, taps_all[0]}) - $signed({2'b00, MID});
      s_val = $signed({2'b00, in_cap}) + (e_val >>> 1);
      if (s_val[DATA_W+1])
         echo_val = '0;
      else if (s_val[DATA_W])
         echo_val = '1;
      else
         echo_val = s_val[DATA_W-1:0];

      case (mode_cap)
         2'd1:    result = mix_val;
         2'd2:    result = echo_val;
         default: result = taps_all[0];
      endcase
      wr_val = (mode_cap == 2'd2) ? result : in_cap;
   end

   // Sample buffer: one synchronous read port, written once per sample in MIX.
   always_ff @(posedge clk) begin
      if (state == MIX)
         mem[wr_ptr] <= wr_val;
      rd_data <= mem[rd_addr];
   end

   // Control FSM with buffer bookkeeping and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         k          <= '0;
         wr_ptr     <= '0;
         fill       <= '0;
         in_cap     <= MID;
         mode_cap   <= 2'd0;
         off_cap    <= '0;
         tap_reg    <= {NUM_TAPS{MID}};
         prim_reg   <= '0;
         out_valid  <= 1'b0;
         out_sample <= MID;
         taps_out   <= {NUM_TAPS{MID}};
         tap_primed <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_cap   <= in_sample;
                  off_cap  <= offsets;
                  mode_cap <= mode;
                  k        <= '0;
                  state    <= READ;
               end
            end
            READ: begin
               if (k != '0) begin
                  tap_reg[pend]  <= pend_val;
                  prim_reg[pend] <= pend_primed;
               end
               if (k == LAST)
                  state <= MIX;
               else
                  k <= k + TAP_W'(1);
            end
            MIX: begin
               out_valid  <= 1'b1;
               out_sample <= result;
               taps_out   <= taps_all;
               tap_primed <= prim_all;
               wr_ptr     <= wr_ptr + ADDR_W'(1);
               if (fill != FILL_MAX)
                  fill <= fill + ADDR_W'(1);
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multitap_delay.sv
// tb/tb_multitap_delay.sv - scoreboard bench for multitap_delay
module tb_multitap_delay;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_sample = 8'd0;
   logic [17:0] offsets = '0;
   logic [1:0]  mode = 2'd0;
   logic        out_valid;
   logic [7:0]  out_sample;
   logic [15:0] taps_out;
   logic [1:0]  tap_primed;

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;

   typedef struct {
      bit         rst_first;
      logic [7:0] s;
      logic [8:0] o0;
      logic [8:0] o1;
      logic [1:0] m;
      int         eo;
      int         e0;
      int         e1;
      logic [1:0] ep;
   } vec_t;

   typedef struct {
      int         o;
      int         t0;
      int         t1;
      logic [1:0] p;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   acc_q[$];

   multitap_delay #(.ADDR_W(9), .DATA_W(8), .NUM_TAPS(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_sample(in_sample), .offsets(offsets), .mode(mode),
      .out_valid(out_valid), .out_sample(out_sample), .taps_out(taps_out),
      .tap_primed(tap_primed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ncyc <= ncyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Scoreboard: every output pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rst && out_valid) begin
         if (exp_q.size() == 0 || acc_q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            exp_t e;
            int   a;
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            chk("out_sample", int'(out_sample), e.o);
            chk("tap0", int'(taps_out[7:0]), e.t0);
            chk("tap1", int'(taps_out[15:8]), e.t1);
            chk("tap_primed", int'(tap_primed), int'(e.p));
            chk("latency", ncyc - a, 4);
         end
      end
   end

   task automatic add(input bit r, input logic [7:0] s, input logic [8:0] o0, input logic [8:0] o1,
                      input logic [1:0] m, input int eo, input int e0, input int e1, input logic [1:0] ep);
      vec_t v;
      v.rst_first = r; v.s = s; v.o0 = o0; v.o1 = o1; v.m = m;
      v.eo = eo; v.e0 = e0; v.e1 = e1; v.ep = ep;
      vecs.push_back(v);
   endtask

   task automatic send(input logic [7:0] s, input logic [8:0] o0, input logic [8:0] o1, input logic [1:0] m,
                       input int eo, input int e0, input int e1, input logic [1:0] ep, input bit track);
      bit done;
      in_sample = s;
      offsets   = {o1, o0};
      mode      = m;
      in_valid  = 1'b1;
      if (track) exp_q.push_back('{eo, e0, e1, ep});
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1;
            if (track) acc_q.push_back(ncyc);
         end
      end
      if (!done) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
      chk("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_in_ready"}, int'(in_ready), 1);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_out_sample"}, int'(out_sample), 128);
      chk({tag, "_taps_out"}, int'(taps_out), 16'h8080);
      chk({tag, "_tap_primed"}, int'(tap_primed), 0);
   endtask

   task automatic do_reset(input bit check);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      if (check) check_idle_outputs("reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);
      if (check) check_idle_outputs("post_reset");
      exp_q.delete();
      acc_q.delete();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int waits;
      // DELAY, tap0=3, tap1=0, ramp
      add(1, 10, 3, 0, 0, 128, 128, 10, 2'b10);
      add(0, 11, 3, 0, 0, 128, 128, 11, 2'b10);
      add(0, 12, 3, 0, 0, 128, 128, 12, 2'b10);
      add(0, 13, 3, 0, 0, 10,  10,  13, 2'b11);
      add(0, 14, 3, 0, 0, 11,  11,  14, 2'b11);
      // MIX, tap0=0, tap1=1
      add(1, 100, 0, 1, 1, 114, 100, 128, 2'b01);
      add(0, 200, 0, 1, 1, 150, 200, 100, 2'b11);
      // ECHO, tap0=2, constant 192
      add(1, 192, 2, 0, 2, 192, 128, 192, 2'b10);
      add(0, 192, 2, 0, 2, 192, 128, 192, 2'b10);
      add(0, 192, 2, 0, 2, 224, 192, 192, 2'b11);
      add(0, 192, 2, 0, 2, 224, 192, 192, 2'b11);
      add(0, 192, 2, 0, 2, 240, 224, 192, 2'b11);
      add(0, 192, 2, 0, 2, 240, 224, 192, 2'b11);
      // ECHO clamp high and low
      add(1, 255, 1, 0, 2, 255, 128, 255, 2'b10);
      add(0, 255, 1, 0, 2, 255, 255, 255, 2'b11);
      add(1, 0,   1, 0, 2, 0,   128, 0,   2'b10);
      add(0, 0,   1, 0, 2, 0,   0,   0,   2'b11);
      // mode 3 behaves as DELAY
      add(1, 50, 1, 0, 3, 128, 128, 50, 2'b10);
      add(0, 60, 1, 0, 3, 50,  50,  60, 2'b11);

      do_reset(1);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst_first) begin
            drain();
            do_reset(0);
         end
         send(vecs[i].s, vecs[i].o0, vecs[i].o1, vecs[i].m,
              vecs[i].eo, vecs[i].e0, vecs[i].e1, vecs[i].ep, 1'b1);
      end
      drain();

      // Wrap: DELAY, tap0=511, 600 samples of i mod 256
      do_reset(0);
      for (int i = 0; i < 600; i++) begin
         int ev;
         ev = (i < 511) ? 128 : ((i - 511) % 256);
         send(8'(i % 256), 9'd511, 9'd0, 2'd0, ev, ev, i % 256,
              (i < 511) ? 2'b10 : 2'b11, 1'b1);
      end
      drain();

      // in_valid held high: acceptance every 4 cycles
      do_reset(0);
      offsets  = {9'd0, 9'd1};
      mode     = 2'd0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bit done;
         in_sample = 8'(20 + i);
         exp_q.push_back('{(i == 0) ? 128 : 19 + i, (i == 0) ? 128 : 19 + i, 20 + i,
                           (i == 0) ? 2'b10 : 2'b11});
         waits = 0;
         done  = 0;
         for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
               done = 1;
               acc_q.push_back(ncyc);
            end else begin
               waits++;
            end
         end
         chk("held_accepted", int'(done), 1);
         chk("held_gap", waits, (i == 0) ? 0 : 3);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      drain();

      // Reset during READ discards the in-flight sample and clears history
      do_reset(0);
      for (int i = 0; i < 4; i++)
         send(8'(30 + i), 9'd1, 9'd0, 2'd0, (i == 0) ? 128 : 29 + i, (i == 0) ? 128 : 29 + i,
              30 + i, (i == 0) ? 2'b10 : 2'b11, 1'b1);
      drain();
      send(8'd99, 9'd1, 9'd0, 2'd0, 0, 0, 0, 2'b00, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      chk("reset_mid_no_output", int'(out_valid), 0);
      @(posedge clk);
      #1;
      send(8'd77, 9'd1, 9'd0, 2'd0, 128, 128, 77, 2'b10, 1'b1);
      drain();

      chk("scoreboard_empty", exp_q.size() + acc_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multitap_delay.md
Name: multitap_delay

Overview:
Parametrised successor to the single-offset delay line. Stores an audio sample stream in a circular buffer and produces NUM_TAPS independently delayed taps, time-multiplexed through one sync RAM read port. A mode input selects plain delay, tap averaging, or feedback echo. Sits between the sample source (mic/ROM) and the DAC/plot output path.

Parameters:
ADDR_W, 9, buffer address width; depth = 2^ADDR_W samples, max offset 2^ADDR_W-1
DATA_W, 8, sample width, unsigned offset-binary (mid-scale MID = 2^(DATA_W-1))
NUM_TAPS, 2, number of delay taps; power of two, >=1

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  sample offered
in_ready  out  1  block can accept a sample this cycle
in_sample  in  DATA_W  input sample
offsets  in  NUM_TAPS*ADDR_W  packed per-tap delay, tap k at [k*ADDR_W +: ADDR_W]
mode  in  2  0 DELAY, 1 MIX, 2 ECHO, 3 treated as DELAY
out_valid  out  1  one-cycle pulse, result ready
out_sample  out  DATA_W  mixed/delayed result
taps_out  out  NUM_TAPS*DATA_W  individual tap values for the current sample
tap_primed  out  NUM_TAPS  tap k held real history (not mid-scale fill)

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, wr_ptr=0, fill count=0, in_ready=1, out_valid=0, out_sample=MID, taps_out all MID, tap_primed=0. RAM contents not cleared; fill count guarantees stale data is never emitted.
- FSM IDLE -> READ(k=0..NUM_TAPS-1) -> MIX -> IDLE. in_ready=1 only in IDLE.
- IDLE: on in_valid&in_ready (cycle t) capture in_sample, offsets, mode.
- READ k (cycles t+1..t+NUM_TAPS): rd_addr = wr_ptr - offset_k, ADDR_W-bit modulo (wraps). Sync RAM, data 1 cycle later.
- Tap value: offset_k==0 -> captured in_sample (bypass, no RAM use). Else if offset_k <= fill -> RAM data, primed. Else -> MID, not primed.
- MIX (cycle t+NUM_TAPS+1): compute result, write RAM[wr_ptr] = write value, wr_ptr+=1 (wraps 2^ADDR_W-1 -> 0), fill = min(fill+1, 2^ADDR_W-1).
- Cycle t+NUM_TAPS+2: out_valid=1 for exactly one cycle, out_sample/taps_out/tap_primed updated and held until next out_valid; FSM in IDLE, in_ready=1. Throughput one sample per NUM_TAPS+2 cycles. No output backpressure.
- DELAY: out=tap0; write value=in_sample.
- MIX: out = (sum of all taps) >> log2(NUM_TAPS); accumulator width DATA_W+log2(NUM_TAPS), no overflow; write value=in_sample.
- ECHO: e = signed(tap0) - MID; out = sat(in_sample + (e >>> 1)) clamped to [0, 2^DATA_W-1]; write value=out (feedback). Other taps still reported on taps_out.
- Offset semantics: offset 1 = previous accepted sample; offset changes take effect only at acceptance.
- Reset mid-operation: in-flight sample discarded, no out_valid, no RAM write; next accepted sample is treated as first (all nonzero-offset taps MID).

Test Plan:
- Reset: rst low -> in_ready=1, out_valid=0, out_sample=128, taps_out={128,128}, tap_primed=0; after release remain so until first acceptance.
- DELAY, offsets tap0=3 tap1=0, ramp 10,11,12,13,14 -> out_sample 128,128,128,10,11; taps_out tap1 = 10..14; out_valid exactly 4 cycles after each acceptance.
- MIX, tap0=0 tap1=1, inputs 100,200 -> outputs (100+128)>>1=114, (200+100)>>1=150; tap_primed 01 then 11.
- Wrap: DELAY, tap0=511, feed 600 samples i mod 256 -> outputs 128 for i<511, out at i=511 equals 0, at i=599 equals 88; wr_ptr wraps cleanly.
- ECHO, tap0=2, constant 192 -> 192,192,224,224,240,240,...; impulse 255 with tap0 history 255 -> out clamps at 255, input 0 with history 0 -> clamps at 0.
- in_valid held high -> accepts every 4 cycles, in_ready low in between; rst pulsed during READ -> no out_valid, next sample output 128 in DELAY with tap0=1.
